controlador_interrupciones: RTL and testbench

Interrupt request controller placed directly upstream of the CPU's `interrupciones[2:0]` input. It:
- synchronizes asynchronous external request lines and detects their rising edges;
- latches requests as pending and applies a software mask;
- selects one request by fixed priority and holds it one-hot toward the CPU until the CPU acknowledges it and signals end of service.

At most one interrupt is outstanding at a time.

---
 rtl/controlador_interrupciones.sv | 121 ++++++++++++
 tb/tb_controlador_interrupciones.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_interrupciones.sv
// Interrupt request controller: synchronizes external lines, latches pending requests,
// applies a software mask and presents one fixed-priority winner to the CPU.
// Define INTC_LEVEL_EN to build the level-sensitive variant (no edge latching).
module controlador_interrupciones #(
  parameter int ANCHO       = 3,
  parameter int ETAPAS_SYNC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] irq_ext,
  input  logic             we_mascara,
  input  logic [ANCHO-1:0] mascara_in,
  input  logic             ack,
  input  logic             fin,
  output logic [ANCHO-1:0] interrupciones,
  output logic [ANCHO-1:0] pendientes,
  output logic [ANCHO-1:0] perdidas,
  output logic             ocupado
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} estado_t;

  estado_t          estado, estado_sig;
  logic [ANCHO-1:0] sync_q [ETAPAS_SYNC];
  logic [ANCHO-1:0] sync_val;
  logic [ANCHO-1:0] mascara;
  logic [ANCHO-1:0] seleccion;
  logic [ANCHO-1:0] ganador;
  logic [ANCHO-1:0] int_sig;
  logic             ocupado_sig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ETAPAS_SYNC; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_ext;
      for (int i = 1; i < ETAPAS_SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_val = sync_q[ETAPAS_SYNC-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          mascara <= '1;
    else if (we_mascara) mascara <= mascara_in;
  end

`ifdef INTC_LEVEL_EN
  // Pending simply mirrors the synchronized lines; the source must drop its request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pendientes <= '0;
    else        pendientes <= sync_val;
  end

  assign perdidas = '0;
`else
  logic [ANCHO-1:0] edge_q;
  logic [ANCHO-1:0] flancos;
  logic [ANCHO-1:0] limpiar;

  assign flancos = sync_val & ~edge_q;
  assign limpiar = (estado == REQ && ack) ? interrupciones : '0;

  // A new edge beats a simultaneous ack-clear; it only counts as lost if the bit stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_q     <= '0;
      pendientes <= '0;
      perdidas   <= '0;
    end else begin
      edge_q     <= sync_val;
      pendientes <= (pendientes & ~limpiar) | flancos;
      perdidas   <= (we_mascara ? '0 : perdidas) | (flancos & pendientes & ~limpiar);
    end
  end
`endif

  // Lowest set bit of the enabled pending set wins.
  assign seleccion = pendientes & mascara;
  assign ganador   = seleccion & (~seleccion + ANCHO'(1));

  always_comb begin
    estado_sig = estado;
    int_sig    = interrupciones;
    case (estado)
      IDLE: begin
        if (|seleccion) begin
          int_sig    = ganador;
          estado_sig = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          int_sig    = '0;
          estado_sig = SERV;
        end
      end
      SERV: begin
        if (fin) estado_sig = IDLE;
      end
      default: begin
        int_sig    = '0;
        estado_sig = IDLE;
      end
    endcase
    ocupado_sig = (estado_sig != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado         <= IDLE;
      interrupciones <= '0;
      ocupado        <= 1'b0;
    end else begin
      estado         <= estado_sig;
      interrupciones <= int_sig;
      ocupado        <= ocupado_sig;
    end
  end

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Self-checking bench for controlador_interrupciones (default edge-latched build):
// directed scenarios plus randomized traffic against a behavioural reference model.
module tb_controlador_interrupciones;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] irq_ext;
  logic       we_mascara;
  logic [2:0] mascara_in;
  logic       ack;
  logic       fin;
  logic [2:0] interrupciones;
  logic [2:0] pendientes;
  logic [2:0] perdidas;
  logic       ocupado;

  int total = 0;
  int bad   = 0;

  // Reference model: history of sampled lines, pending/lost/mask bits, the presented
  // line and a phase number (0 idle, 1 presented, 2 in service).
  logic [2:0] hist [4];
  logic [2:0] pend_m, perd_m, mask_m, pres_m;
  int         fase;

  controlador_interrupciones #(.ANCHO(3), .ETAPAS_SYNC(2)) dut (
    .clk(clk),
    .reset(reset),
    .irq_ext(irq_ext),
    .we_mascara(we_mascara),
    .mascara_in(mascara_in),
    .ack(ack),
    .fin(fin),
    .interrupciones(interrupciones),
    .pendientes(pendientes),
    .perdidas(perdidas),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) hist[i] = 3'b000;
    pend_m = 3'b000;
    perd_m = 3'b000;
    mask_m = 3'b111;
    pres_m = 3'b000;
    fase   = 0;
  endfunction

  // One clock edge: a line rises in the model two samples after it was seen high
  // following a low sample; priority is a scan from index 0 upward.
  function automatic void model_step();
    logic [2:0] flanco, clear, loss;
    int win;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irq_ext;
    flanco = hist[2] & ~hist[3];
    win = -1;
    for (int i = 0; i < 3; i++)
      if (win < 0 && pend_m[i] && mask_m[i]) win = i;
    clear  = (fase == 1 && ack) ? pres_m : 3'b000;
    loss   = flanco & pend_m & ~clear;
    pend_m = (pend_m & ~clear) | flanco;
    perd_m = (we_mascara ? 3'b000 : perd_m) | loss;
    if (fase == 0) begin
      if (win >= 0) begin
        pres_m = 3'(1 << win);
        fase   = 1;
      end
    end else if (fase == 1) begin
      if (ack) begin
        pres_m = 3'b000;
        fase   = 2;
      end
    end else begin
      if (fin) fase = 0;
    end
    if (we_mascara) mask_m = mascara_in;
  endfunction

  task automatic applyStimulus(input logic [2:0] irq, input logic we, input logic [2:0] m,
                               input logic a, input logic f);
    irq_ext    = irq;
    we_mascara = we;
    mascara_in = m;
    ack        = a;
    fin        = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput("interrupciones", interrupciones, pres_m);
    checkOutput("pendientes", pendientes, pend_m);
    checkOutput("perdidas", perdidas, perd_m);
    checkOutput("ocupado", {2'b00, ocupado}, {2'b00, fase != 0});
  endtask

  task automatic do_reset(input logic [2:0] irq);
    reset      = 1'b0;
    irq_ext    = irq;
    we_mascara = 1'b0;
    mascara_in = 3'b000;
    ack        = 1'b0;
    fin        = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  logic [2:0] irq_r;

  initial begin
    do_reset(3'b000);
    checkOutput("reset_int", interrupciones, 3'b000);
    checkOutput("reset_pend", pendientes, 3'b000);
    checkOutput("reset_perd", perdidas, 3'b000);
    checkOutput("reset_ocup", {2'b00, ocupado}, 3'b000);

    // Single request on line 1: presented four edges after the pulse.
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0, 1'b0);
    idle_cycles(3);
    checkOutput("single_present", interrupciones, 3'b010);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
    checkOutput("single_ack_pend", pendientes, 3'b000);
    checkOutput("single_ack_int", interrupciones, 3'b000);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("single_fin_ocup", {2'b00, ocupado}, 3'b000);

    // Lines 2 and 0 together: line 0 first, line 2 one cycle after fin.
    applyStimulus(3'b101, 1'b0, 3'b000, 1'b0, 1'b0);
    idle_cycles(3);
    checkOutput("prio_first", interrupciones, 3'b001);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    idle_cycles(1);
    checkOutput("prio_second", interrupciones, 3'b100);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);

    // Masked line 0 latches pending but is not presented until re-enabled.
    applyStimulus(3'b000, 1'b1, 3'b110, 1'b0, 1'b0);
    applyStimulus(3'b001, 1'b0, 3'b000, 1'b0, 1'b0);
    idle_cycles(3);
    checkOutput("mask_pend", pendientes, 3'b001);
    checkOutput("mask_nopresent", interrupciones, 3'b000);
    applyStimulus(3'b000, 1'b1, 3'b111, 1'b0, 1'b0);
    idle_cycles(1);
    checkOutput("mask_present", interrupciones, 3'b001);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);

    // Two edges on line 1 before ack: lost flag is sticky until a mask write.
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0, 1'b0);
    idle_cycles(3);
    checkOutput("lost_flag", perdidas, 3'b010);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("lost_sticky", perdidas, 3'b010);
    applyStimulus(3'b000, 1'b1, 3'b111, 1'b0, 1'b0);
    checkOutput("lost_cleared", perdidas, 3'b000);

    // Ack coincident with a new edge on the presented line: set wins, no loss.
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0, 1'b0);
    idle_cycles(3);
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
    checkOutput("hazard_pend", pendientes, 3'b010);
    checkOutput("hazard_perd", perdidas, 3'b000);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);

    // Asynchronous reset while a request is presented, between clock edges.
    applyStimulus(3'b100, 1'b0, 3'b000, 1'b0, 1'b0);
    idle_cycles(3);
    checkOutput("async_pre", interrupciones, 3'b100);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_int", interrupciones, 3'b000);
    checkOutput("async_pend", pendientes, 3'b000);
    checkOutput("async_perd", perdidas, 3'b000);
    checkOutput("async_ocup", {2'b00, ocupado}, 3'b000);
    do_reset(3'b000);

    // Line held high across reset release counts as a single edge.
    do_reset(3'b100);
    for (int i = 0; i < 4; i++) applyStimulus(3'b100, 1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("held_present", interrupciones, 3'b100);
    applyStimulus(3'b100, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(3'b100, 1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(3'b100, 1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("held_once", {2'b00, ocupado}, 3'b000);

    // Randomized traffic with an occasional mid-run asynchronous reset.
    irq_r = 3'b000;
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        #2 reset = 1'b0;
        #1;
        checkOutput("rand_async_int", interrupciones, 3'b000);
        do_reset(irq_r);
      end
      irq_r = irq_r ^ (3'($urandom) & 3'($urandom) & 3'($urandom));
      applyStimulus(irq_r, ($urandom % 24) == 0, 3'($urandom),
                    ($urandom % 3) == 0, ($urandom % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
